// File: rtl/miner_nonce_ctrl.sv
// Nonce search controller for a double-SHA-256 mining core.
// Walks nonces, issues one hash at a time, compares digest to target.
module miner_nonce_ctrl #(
   parameter logic [31:0] NONCE_LIMIT = 32'hFFFFFFFF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         config_use_nonce_in,
   input  logic         config_oneshot,
   input  logic [31:0]  nonce_in,
   input  logic [31:0]  bits,
   output logic         hash_req_valid,
   input  logic         hash_req_ready,
   output logic [31:0]  header_nonce,
   input  logic         hash_rsp_valid,
   input  logic [255:0] hash_rsp_data,
   output logic [31:0]  nonce,
   output logic         done,
   output logic         nonce_found,
   output logic         busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] CMP  = 2'd3;

   logic [1:0]   state;
   logic [31:0]  cur_nonce;
   logic [255:0] target;
   logic [255:0] digest;
   logic [255:0] tgt_next;
   logic [7:0]   exp_b;
   logic [22:0]  man;
   logic [7:0]   shl;
   logic         hit;

   assign exp_b = bits[31:24];
   assign man   = bits[22:0];
   assign shl   = (exp_b - 8'd3) << 3;

   assign hash_req_valid = (state == REQ);
   assign header_nonce   = cur_nonce;
   assign busy           = (state != IDLE);
   assign hit            = (digest <= target);

   // Expand the compact difficulty encoding into a 256-bit target
   always_comb begin
      tgt_next = '0;
      if (bits[23] || (man == 23'd0)) begin
         tgt_next = '0;
      end else if (exp_b <= 8'd3) begin
         case (exp_b[1:0])
            2'd1:    tgt_next = {233'd0, man} >> 16;
            2'd2:    tgt_next = {233'd0, man} >> 8;
            2'd3:    tgt_next = {233'd0, man};
            default: tgt_next = '0;
         endcase
      end else if (exp_b <= 8'd32) begin
         tgt_next = {233'd0, man} << shl;
      end else begin
         tgt_next = '1;
      end
   end

   // Search FSM: issue request, wait for digest, compare, advance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cur_nonce   <= '0;
         target      <= '0;
         digest      <= '0;
         nonce       <= '0;
         done        <= 1'b0;
         nonce_found <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  target      <= tgt_next;
                  cur_nonce   <= config_use_nonce_in ? nonce_in : 32'd0;
                  done        <= 1'b0;
                  nonce_found <= 1'b0;
                  state       <= REQ;
               end
            end
            REQ: begin
               if (hash_req_ready) state <= WAIT;
            end
            WAIT: begin
               if (hash_rsp_valid) begin
                  digest <= hash_rsp_data;
                  state  <= CMP;
               end
            end
            default: begin
               if (hit) begin
                  nonce       <= cur_nonce;
                  nonce_found <= 1'b1;
                  done        <= 1'b1;
                  state       <= IDLE;
               end else if (config_oneshot || (cur_nonce == NONCE_LIMIT)) begin
                  nonce       <= cur_nonce;
                  nonce_found <= 1'b0;
                  done        <= 1'b1;
                  state       <= IDLE;
               end else begin
                  cur_nonce <= cur_nonce + 32'd1;
                  state     <= REQ;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_miner_nonce_ctrl.sv
// Directed bench for miner_nonce_ctrl: vector table plus
// hand sequences for stall, restart-ignore and reset-in-WAIT.
module tb_miner_nonce_ctrl;

   logic         clk;
   logic         rst;
   logic         start;
   logic         config_use_nonce_in;
   logic         config_oneshot;
   logic [31:0]  nonce_in;
   logic [31:0]  bits;
   logic         hash_req_valid;
   logic         hash_req_ready;
   logic [31:0]  header_nonce;
   logic         hash_rsp_valid;
   logic [255:0] hash_rsp_data;
   logic [31:0]  nonce;
   logic         done;
   logic         nonce_found;
   logic         busy;

   int checks = 0;
   int errors = 0;

   miner_nonce_ctrl dut (
      .clk                 (clk),
      .rst                 (rst),
      .start               (start),
      .config_use_nonce_in (config_use_nonce_in),
      .config_oneshot      (config_oneshot),
      .nonce_in            (nonce_in),
      .bits                (bits),
      .hash_req_valid      (hash_req_valid),
      .hash_req_ready      (hash_req_ready),
      .header_nonce        (header_nonce),
      .hash_rsp_valid      (hash_rsp_valid),
      .hash_rsp_data       (hash_rsp_data),
      .nonce               (nonce),
      .done                (done),
      .nonce_found         (nonce_found),
      .busy                (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [31:0]  bits;
      logic         use_in;
      logic [31:0]  nonce_in;
      logic         oneshot;
      int           hit_idx;
      logic [255:0] hit_dig;
      logic [255:0] miss_dig;
      logic [31:0]  exp_nonce;
      logic         exp_found;
      int           exp_reqs;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [255:0] act,
                      input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string name);
      chk({name, ".valid"}, 256'(hash_req_valid), 256'd0);
      chk({name, ".hdr"}, 256'(header_nonce), 256'd0);
      chk({name, ".nonce"}, 256'(nonce), 256'd0);
      chk({name, ".done"}, 256'(done), 256'd0);
      chk({name, ".found"}, 256'(nonce_found), 256'd0);
      chk({name, ".busy"}, 256'(busy), 256'd0);
   endtask

   task automatic run_vec(input vec_t v);
      int reqs = 0;
      int cyc = 0;
      bit fin = 0;
      logic [31:0] first;
      first = v.use_in ? v.nonce_in : 32'd0;
      @(negedge clk);
      bits = v.bits;
      nonce_in = v.nonce_in;
      config_use_nonce_in = v.use_in;
      config_oneshot = v.oneshot;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!fin && cyc < 400) begin
         if (done) begin
            fin = 1;
         end else if (hash_req_valid) begin
            chk({v.name, ".hdr"}, 256'(header_nonce), 256'(first + 32'(reqs)));
            hash_req_ready = 1'b1;
            @(negedge clk);
            hash_req_ready = 1'b0;
            @(negedge clk);
            hash_rsp_data = (reqs == v.hit_idx) ? v.hit_dig : v.miss_dig;
            hash_rsp_valid = 1'b1;
            @(negedge clk);
            hash_rsp_valid = 1'b0;
            reqs++;
         end else begin
            @(negedge clk);
         end
         cyc++;
      end
      chk({v.name, ".finished"}, 256'(fin), 256'd1);
      chk({v.name, ".found"}, 256'(nonce_found), 256'(v.exp_found));
      chk({v.name, ".nonce"}, 256'(nonce), 256'(v.exp_nonce));
      chk({v.name, ".reqs"}, 256'(reqs), 256'(v.exp_reqs));
      repeat (4) @(negedge clk);
      chk({v.name, ".no_extra_req"}, 256'(hash_req_valid), 256'd0);
      chk({v.name, ".done_held"}, 256'(done), 256'd1);
      chk({v.name, ".busy"}, 256'(busy), 256'd0);
   endtask

   initial begin
      logic [255:0] ones;
      logic [255:0] t1d;
      ones = '1;
      t1d = 256'hFFFF << 208;

      vecs.push_back('{"easy_hit", 32'h207FFFFF, 1'b1, 32'd5, 1'b0, 0,
                       256'd1, ones, 32'd5, 1'b1, 1});
      vecs.push_back('{"walk4", 32'h1D00FFFF, 1'b0, 32'h99, 1'b0, 3,
                       256'hFF << 216, t1d + 256'd1, 32'd3, 1'b1, 4});
      vecs.push_back('{"oneshot", 32'h1D00FFFF, 1'b1, 32'h1234, 1'b1, 99,
                       ones, ones, 32'h1234, 1'b0, 1});
      vecs.push_back('{"limit", 32'h1D00FFFF, 1'b1, 32'hFFFFFFFF, 1'b0, 99,
                       ones, ones, 32'hFFFFFFFF, 1'b0, 1});
      vecs.push_back('{"e3_equal", 32'h03123456, 1'b1, 32'h10, 1'b0, 0,
                       256'h123456, ones, 32'h10, 1'b1, 1});
      vecs.push_back('{"e3_above", 32'h03123456, 1'b1, 32'h20, 1'b1, 99,
                       ones, 256'h123457, 32'h20, 1'b0, 1});
      vecs.push_back('{"e1_equal", 32'h01123456, 1'b0, 32'h0, 1'b0, 1,
                       256'h12, 256'h13, 32'h1, 1'b1, 2});
      vecs.push_back('{"sign_zero", 32'h04800001, 1'b1, 32'h7, 1'b0, 2,
                       256'd0, 256'd1, 32'h9, 1'b1, 3});
      vecs.push_back('{"mant_zero", 32'h1D000000, 1'b1, 32'h3, 1'b1, 99,
                       ones, 256'd1, 32'h3, 1'b0, 1});
      vecs.push_back('{"e_big", 32'h21000001, 1'b1, 32'h44, 1'b0, 0,
                       ones, ones, 32'h44, 1'b1, 1});
      vecs.push_back('{"e32_top", 32'h207FFFFF, 1'b1, 32'h50, 1'b0, 1,
                       256'h7FFFFF << 232, ones, 32'h51, 1'b1, 2});

      rst = 1'b1;
      start = 1'b0;
      config_use_nonce_in = 1'b0;
      config_oneshot = 1'b0;
      nonce_in = '0;
      bits = '0;
      hash_req_ready = 1'b0;
      hash_rsp_valid = 1'b0;
      hash_rsp_data = '0;
      #1;
      chk_idle_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Stall with ready low; a second start must be ignored
      @(negedge clk);
      bits = 32'h1D00FFFF;
      nonce_in = 32'hABCD;
      config_use_nonce_in = 1'b1;
      config_oneshot = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("stall.done_cleared", 256'(done), 256'd0);
      for (int c = 0; c < 10; c++) begin
         chk("stall.valid", 256'(hash_req_valid), 256'd1);
         chk("stall.hdr", 256'(header_nonce), 256'h0ABCD);
         if (c == 3) begin
            nonce_in = 32'h5555;
            config_use_nonce_in = 1'b0;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      config_use_nonce_in = 1'b1;
      chk("stall.hdr_final", 256'(header_nonce), 256'h0ABCD);
      hash_req_ready = 1'b1;
      @(negedge clk);
      hash_req_ready = 1'b0;
      chk("stall.valid_drop", 256'(hash_req_valid), 256'd0);
      @(negedge clk);
      hash_rsp_data = ones;
      hash_rsp_valid = 1'b1;
      @(negedge clk);
      hash_rsp_valid = 1'b0;
      @(negedge clk);
      chk("stall.done", 256'(done), 256'd1);
      chk("stall.found", 256'(nonce_found), 256'd0);
      chk("stall.nonce", 256'(nonce), 256'h0ABCD);

      // Reset while waiting for a digest
      @(negedge clk);
      config_oneshot = 1'b0;
      nonce_in = 32'h77;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hash_req_ready = 1'b1;
      @(negedge clk);
      hash_req_ready = 1'b0;
      chk("rstwait.in_wait", 256'(busy), 256'd1);
      #2 rst = 1'b1;
      #1;
      chk_idle_outputs("rstwait");
      @(negedge clk);
      rst = 1'b0;
      hash_rsp_data = 256'd0;
      hash_rsp_valid = 1'b1;
      @(negedge clk);
      hash_rsp_valid = 1'b0;
      @(negedge clk);
      chk_idle_outputs("late_rsp");

      run_vec('{"after_rst", 32'h207FFFFF, 1'b1, 32'h5, 1'b0, 0,
                256'd1, ones, 32'd5, 1'b1, 1});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/miner_nonce_ctrl.md
MINER_NONCE_CTRL -- requirements
Module: miner_nonce_ctrl

Interface
REQ-001 Parameter: NONCE_LIMIT, 32'hFFFFFFFF, last nonce tried before the search terminates without a hit.
REQ-002 clk  in  1  single clock for all logic.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 start  in  1  one-cycle pulse from the register block; requests a new search.
REQ-005 config_use_nonce_in  in  1  1: first nonce = nonce_in; 0: first nonce = 0.
REQ-006 config_oneshot  in  1  1: hash exactly one nonce, then finish.
REQ-007 nonce_in  in  32  programmed starting nonce.
REQ-008 bits  in  32  compact difficulty target (exponent [31:24], sign [23], mantissa [22:0]).
REQ-009 hash_req_valid  out  1  request to the double-SHA-256 core.
REQ-010 hash_req_ready  in  1  core accepts the request.
REQ-011 header_nonce  out  32  nonce presented with the request; all other header fields go to the core directly, not through this block.
REQ-012 hash_rsp_valid  in  1  one-cycle pulse; digest valid.
REQ-013 hash_rsp_data  in  256  final digest as an unsigned integer, bit 255 = MSB (core already performs byte reversal).
REQ-014 nonce  out  32  result nonce; valid while done=1.
REQ-015 done  out  1  level; search finished.
REQ-016 nonce_found  out  1  level; digest <= target for nonce.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, REQ, WAIT, CMP; reset state IDLE.
REQ-019 IDLE + start: capture target from bits; cur_nonce = config_use_nonce_in ? nonce_in : 0; clear done and nonce_found; go to REQ. hash_req_valid is high on the next cycle (1-cycle latency).
REQ-020 Any start outside IDLE: ignore it with no side effect.
REQ-021 Target expansion, E=bits[31:24], M=bits[22:0]: bits[23]=1 or M=0 -> target 0; E<=3 -> M >> 8*(3-E); 4<=E<=32 -> M << 8*(E-3), 256-bit; E>32 -> target all ones.
REQ-022 REQ: hash_req_valid=1 and header_nonce=cur_nonce; both held stable until hash_req_ready; the cycle valid&ready is high, go to WAIT and deassert valid.
REQ-023 WAIT: on hash_rsp_valid, register the digest and go to CMP; hash_rsp_valid in any other state is ignored.
REQ-024 CMP, single cycle, 256-bit unsigned compare, priority order:
- digest <= target -> nonce=cur_nonce, nonce_found=1, done=1, go to IDLE.
- else if config_oneshot -> nonce=cur_nonce, nonce_found=0, done=1, go to IDLE.
- else if cur_nonce==NONCE_LIMIT -> nonce=cur_nonce, nonce_found=0, done=1, go to IDLE; no wrap-around.
- else cur_nonce+1 (32-bit) and go to REQ.
REQ-025 config_oneshot and config_use_nonce_in are sampled live; bits and nonce_in are used only at start.
REQ-026 Only one request is outstanding at a time.
REQ-027 done, nonce_found and nonce hold until the next accepted start or reset.

Reset
REQ-028 rst asynchronously forces state IDLE and drives hash_req_valid, header_nonce, nonce, done, nonce_found, busy, target and cur_nonce to 0, in any state.
REQ-029 After reset: a late hash_rsp_valid is ignored, and the first start behaves per REQ-019.

Verification
REQ-030 bits=0x207FFFFF, use_nonce_in=1, nonce_in=5, digest=1 -> one request with header_nonce=5; done=1, nonce_found=1, nonce=5.
REQ-031 bits=0x1D00FFFF (target 0xFFFF<<208), nonce start 0, digests above target for nonces 0-2 and 0x00000000FF...0 for nonce 3 -> exactly 4 requests; nonce=3, nonce_found=1.
REQ-032 config_oneshot=1, nonce_in=0x1234, use_nonce_in=1, digest all ones -> exactly 1 request; done=1, nonce_found=0, nonce=0x1234.
REQ-033 nonce_in=0xFFFFFFFF, use_nonce_in=1, digest miss -> 1 request; done=1, nonce_found=0, nonce=0xFFFFFFFF; no second request.
REQ-034 hash_req_ready held low 10 cycles, with start pulsed again during that time -> valid and header_nonce stable throughout; second start has no effect.
REQ-035 rst asserted in WAIT -> all outputs 0 in the same cycle; a subsequent hash_rsp_valid causes no state change; a new start searches normally.
